pipeline_stall_ctrl: RTL and testbench

Pipeline control sequencer that consumes the hazard detection unit's load-use stall request, the ID-stage branch flush and the debug unit's run/step commands. It drives the per-stage write enables, flush and bubble controls of the 5-stage MIPS pipeline. It also owns the HALT drain sequence and an optional stall-cycle counter readable by the debug unit. It sits between the hazard/branch logic in ID and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 20 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared FSM encodings and drain default for the pipeline sequencer
package pipeline_stall_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int DEFAULT_DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_STEP   = ST_STEP,
    S_DRAIN  = ST_DRAIN,
    S_HALTED = ST_HALTED
  } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - saturating up-counter with enable
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline stall/flush/halt sequencer for the 5-stage pipeline
// STALL_COUNTER_EN adds the saturating stall-cycle counter; otherwise o_stall_count is 0.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int N_BITS_CNT   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush_branch,
  input  logic                  i_halt_id,
  input  logic                  i_dbg_run,
  input  logic                  i_dbg_step,
  output logic                  o_pc_we,
  output logic                  o_ifid_we,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_pipe_en,
  output logic                  o_halted,
  output logic [N_BITS_CNT-1:0] o_stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t        state, state_next;
  logic [DW-1:0] drain_cnt;
  logic          advancing;

  assign advancing = (state == S_RUN) || (state == S_STEP);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
    end
  end

  always_comb begin
    state_next    = state;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_dbg_run) begin
          state_next = S_RUN;
        end else if (i_dbg_step) begin
          state_next = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        o_pipe_en     = 1'b1;
        o_pc_we       = ~i_stall;
        o_ifid_we     = ~i_stall;
        o_idex_bubble = i_stall;
        o_ifid_flush  = i_flush_branch & ~i_stall;
        // HALT moves on into ID/EX while fetch is frozen and IF/ID is cleared
        if (i_halt_id && !i_stall) begin
          o_pc_we      = 1'b0;
          o_ifid_flush = 1'b1;
          state_next   = S_DRAIN;
        end else if (state == S_STEP) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
        o_pipe_en     = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_next = S_HALTED;
        end
      end
      S_HALTED: begin
        state_next = S_HALTED;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign o_halted = (state == S_HALTED);

`ifdef STALL_COUNTER_EN
  sat_counter #(
    .WIDTH(N_BITS_CNT)
  ) u_stall_cnt (
    .clk  (i_clock),
    .rst  (i_reset),
    .en   (advancing & i_stall),
    .count(o_stall_count)
  );
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stall, flush_branch, halt_id, dbg_run, dbg_step;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en, halted;
  logic [31:0] stall_count;

  int n_cmp;
  int n_bad;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en, halted}
  localparam logic [5:0] O_ZERO   = 6'b000000;
  localparam logic [5:0] O_RUN    = 6'b110010;
  localparam logic [5:0] O_STALL  = 6'b000110;
  localparam logic [5:0] O_FLUSH  = 6'b111010;
  localparam logic [5:0] O_HALTID = 6'b011010;
  localparam logic [5:0] O_DRAIN  = 6'b001110;
  localparam logic [5:0] O_HALTED = 6'b000001;

  pipeline_stall_ctrl #(
    .DRAIN_CYCLES(3),
    .N_BITS_CNT  (32)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_stall       (stall),
    .i_flush_branch(flush_branch),
    .i_halt_id     (halt_id),
    .i_dbg_run     (dbg_run),
    .i_dbg_step    (dbg_step),
    .o_pc_we       (pc_we),
    .o_ifid_we     (ifid_we),
    .o_ifid_flush  (ifid_flush),
    .o_idex_bubble (idex_bubble),
    .o_pipe_en     (pipe_en),
    .o_halted      (halted),
    .o_stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef STALL_COUNTER_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp);
    #1;
    check_eq(tag, {26'd0, pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en, halted}, {26'd0, exp});
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    {stall, flush_branch, halt_id, dbg_run, dbg_step} = '0;
    next_cyc();
    check_outs("reset_outs", O_ZERO);
    check_eq("reset_cnt", stall_count, 32'd0);
    rst = 1'b0;

    dbg_run = 1'b1;
    check_outs("idle_outs", O_ZERO);
    next_cyc();
    dbg_run = 1'b0;
    check_outs("run_outs", O_RUN);
    check_eq("run_cnt0", stall_count, 32'd0);

    stall = 1'b1;
    check_outs("stall_c1", O_STALL);
    next_cyc();
    check_outs("stall_c2", O_STALL);
    next_cyc();
    stall = 1'b0;
    check_outs("stall_end", O_RUN);
    check_eq("stall_cnt2", stall_count, exp_cnt(2));

    stall = 1'b1;
    flush_branch = 1'b1;
    check_outs("stall_beats_flush", O_STALL);
    next_cyc();
    stall = 1'b0;
    check_outs("flush_after_stall", O_FLUSH);
    next_cyc();
    flush_branch = 1'b0;
    check_eq("stall_cnt3", stall_count, exp_cnt(3));

    stall = 1'b1;
    halt_id = 1'b1;
    check_outs("halt_stalled", O_STALL);
    next_cyc();
    stall = 1'b0;
    check_outs("halt_taken", O_HALTID);
    next_cyc();
    halt_id = 1'b0;
    dbg_run = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_outs($sformatf("drain_%0d", i), O_DRAIN);
      next_cyc();
    end
    dbg_run = 1'b0;
    stall = 1'b0;
    check_outs("halted", O_HALTED);
    check_eq("halted_cnt4", stall_count, exp_cnt(4));
    dbg_run = 1'b1;
    next_cyc();
    dbg_run = 1'b0;
    next_cyc();
    check_outs("halted_ignores_run", O_HALTED);

    rst = 1'b1;
    check_outs("reset_from_halted", O_ZERO);
    check_eq("reset_cnt_clear", stall_count, 32'd0);
    next_cyc();
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      dbg_step = 1'b1;
      check_outs($sformatf("step%0d_idle", k), O_ZERO);
      next_cyc();
      dbg_step = 1'b0;
      check_outs($sformatf("step%0d_adv", k), O_RUN);
      for (int j = 0; j < 3; j++) begin
        next_cyc();
        check_outs($sformatf("step%0d_wait%0d", k, j), O_ZERO);
      end
    end

    dbg_step = 1'b1;
    next_cyc();
    dbg_step = 1'b0;
    stall = 1'b1;
    check_outs("step_stalled", O_STALL);
    next_cyc();
    stall = 1'b0;
    check_outs("step_stalled_idle", O_ZERO);
    check_eq("step_stall_cnt", stall_count, exp_cnt(1));

    dbg_step = 1'b1;
    next_cyc();
    dbg_step = 1'b0;
    halt_id = 1'b1;
    check_outs("step_halt", O_HALTID);
    next_cyc();
    halt_id = 1'b0;
    check_outs("step_drain0", O_DRAIN);
    next_cyc();
    check_outs("step_drain1", O_DRAIN);
    rst = 1'b1;
    check_outs("reset_mid_drain", O_ZERO);
    check_eq("reset_mid_drain_cnt", stall_count, 32'd0);
    next_cyc();
    rst = 1'b0;
    next_cyc();
    check_outs("idle_after_reset", O_ZERO);

    dbg_run = 1'b1;
    dbg_step = 1'b1;
    next_cyc();
    dbg_run = 1'b0;
    dbg_step = 1'b0;
    check_outs("run_wins_c1", O_RUN);
    next_cyc();
    check_outs("run_wins_c2", O_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
